// File: rtl/alu_result_checker.sv
// alu_result_checker
//   Consumer side of the duplicated (fault-tolerant) ALU. Captures the X/Y
//   result pair and classifies it using the two-rail error codes and an X-vs-Y
//   compare. It delivers one checked result per transaction over valid/ready.
//   A bad result asks the issuer to re-drive the operands, up to MAX_RETRY
//   times. After that the X result is delivered with FATAL status.
//   The block also keeps saturating statistics and a sticky fatal flag.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   in_valid / in_ready         result pair handshake (ready only in idle, rst low)
//   x, xc, xe0, xe1             channel X sum, carry, two-rail code
//   y, yc, ye0, ye1             channel Y sum, carry, two-rail code
//   retry_req                   one-cycle pulse: re-issue the same operands
//   out_valid / out_ready       checked result handshake
//   out_data, out_carry         delivered sum and carry
//   out_status                  00 OK, 01 CORRECTED, 10 FATAL
//   corr_cnt, retry_cnt         saturating statistics
//   fatal                       sticky, set on any FATAL delivery
module alu_result_checker #(
  parameter int W         = 3,
  parameter int MAX_RETRY = 2,
  parameter int CW        = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  x,
  input  logic          xc,
  input  logic          xe0,
  input  logic          xe1,
  input  logic [W-1:0]  y,
  input  logic          yc,
  input  logic          ye0,
  input  logic          ye1,
  output logic          retry_req,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          out_carry,
  output logic [1:0]    out_status,
  output logic [CW-1:0] corr_cnt,
  output logic [CW-1:0] retry_cnt,
  output logic          fatal
);

  localparam int TW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_CORR  = 2'b01;
  localparam logic [1:0] ST_FATAL = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_OUT, S_RETRY} state_t;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         carry;
  } res_t;

  state_t       state;
  logic [TW-1:0] tries;

  res_t x_res, y_res, sel_res;
  logic x_ok, y_ok, match, single, bad, do_retry;

  assign in_ready = (state == S_IDLE) && !rst;

  // A valid two-rail code has complementary rails. 00 and 11 are both errors.
  assign x_ok  = xe0 ^ xe1;
  assign y_ok  = ye0 ^ ye1;
  assign x_res = '{sum: x, carry: xc};
  assign y_res = '{sum: y, carry: yc};
  assign match = (x_res == y_res);

  assign single   = x_ok ^ y_ok;
  assign bad      = (x_ok && y_ok && !match) || (!x_ok && !y_ok);
  assign do_retry = bad && (tries < TW'(MAX_RETRY));

  // Only a single-ok result takes Y. Good and fatal results both deliver X.
  assign sel_res = (single && y_ok) ? y_res : x_res;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      tries      <= '0;
      retry_req  <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_carry  <= 1'b0;
      out_status <= ST_OK;
      corr_cnt   <= '0;
      retry_cnt  <= '0;
      fatal      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // in_ready is simply "idle and not in reset", so in_valid here is a capture.
          if (in_valid) begin
            if (do_retry) begin
              state     <= S_RETRY;
              retry_req <= 1'b1;
              tries     <= tries + 1'b1;
              if (retry_cnt != '1) retry_cnt <= retry_cnt + 1'b1;
            end else begin
              state     <= S_OUT;
              out_valid <= 1'b1;
              out_data  <= sel_res.sum;
              out_carry <= sel_res.carry;
              if (bad) begin
                out_status <= ST_FATAL;
                fatal      <= 1'b1;
              end else if (single) begin
                out_status <= ST_CORR;
                if (corr_cnt != '1) corr_cnt <= corr_cnt + 1'b1;
              end else begin
                out_status <= ST_OK;
              end
            end
          end
        end
        S_RETRY: begin
          state     <= S_IDLE;
          retry_req <= 1'b0;
        end
        S_OUT: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            tries     <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
